// File: rtl/ntt_arith_pkg.sv
// Shared NTT arithmetic definitions: op encoding and the pipeline stage payload.
// The payload is sized for the largest supported configuration
// (MAX_LANES lanes, MAX_VAL_W-bit lane values, MAX_TAG_W-bit tag);
// users fill the low bits and leave the rest at zero.
package ntt_arith_pkg;

  localparam int unsigned MAX_LANES = 8;
  localparam int unsigned MAX_VAL_W = 65;
  localparam int unsigned MAX_TAG_W = 32;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic [MAX_TAG_W-1:0]                tag;
    logic [MAX_LANES-1:0]                op;
    logic [MAX_LANES-1:0][MAX_VAL_W-1:0] val;
  } stage_payload_t;

  // True when the op bit selects subtraction.
  function automatic logic op_is_sub(input logic op_bit);
    return (op_e'(op_bit) == OP_SUB);
  endfunction

endpackage

// File: rtl/modaddsub_lane.sv
// One lane of modular add/subtract: the raw sum/difference for stage 1 and
// the single conditional correction for stage 2. Purely combinational.
module modaddsub_lane
  import ntt_arith_pkg::*;
#(
  parameter int unsigned LOGQ = 32
) (
  input  logic [LOGQ-1:0] a,
  input  logic [LOGQ-1:0] b,
  input  logic            op,
  input  logic [LOGQ:0]   held_raw,
  input  logic            held_op,
  input  logic [LOGQ-1:0] q,
  output logic [LOGQ:0]   raw,
  output logic [LOGQ-1:0] res
);

  // Stage-1 arithmetic: one extra bit holds the add carry or the subtract sign.
  always_comb begin
    raw = '0;
    if (op_is_sub(op)) begin
      raw = {1'b0, a} - {1'b0, b};
    end else begin
      raw = {1'b0, a} + {1'b0, b};
    end
  end

  // Stage-2 correction: the low LOGQ bits are exact modulo 2^LOGQ, and the
  // corrected value is below q, so wrap-around arithmetic on them is safe.
  always_comb begin
    res = held_raw[LOGQ-1:0];
    if (op_is_sub(held_op)) begin
      if (held_raw[LOGQ]) begin
        res = held_raw[LOGQ-1:0] + q;
      end else begin
        res = held_raw[LOGQ-1:0];
      end
    end else begin
      if (held_raw >= {1'b0, q}) begin
        res = held_raw[LOGQ-1:0] - q;
      end else begin
        res = held_raw[LOGQ-1:0];
      end
    end
  end

endmodule

// File: rtl/modaddsub_lanes.sv
// Multi-lane modular add/subtract, two-stage valid/ready pipeline.
// q = qH*2^WORD_SIZE + 1 unless Q_VALUE is nonzero.
// Optional feature: define MODADDSUB_RANGE_CHECK_EN to add the sticky
// range_err output flagging any accepted operand >= q.
// LANES, LOGQ+1 and TAG_W must fit the ntt_arith_pkg payload maxima.
module modaddsub_lanes
  import ntt_arith_pkg::*;
#(
  parameter int unsigned     LOGQ      = 32,
  parameter logic [LOGQ-1:0] Q_VALUE   = '0,
  parameter int unsigned     WORD_SIZE = 16,
  parameter int unsigned     LANES     = 4,
  parameter int unsigned     TAG_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef MODADDSUB_RANGE_CHECK_EN
  output logic                      range_err,
`endif
  input  logic [LOGQ-WORD_SIZE-1:0] qH,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0]          in_op,
  input  logic [LANES*LOGQ-1:0]     in_a,
  input  logic [LANES*LOGQ-1:0]     in_b,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LOGQ-1:0]     out_c,
  output logic [TAG_W-1:0]          out_tag
);

  logic [LOGQ-1:0]             q_s;
  stage_payload_t              s1_r;
  stage_payload_t              s2_r;
  stage_payload_t              s1_next_s;
  stage_payload_t              s2_next_s;
  logic                        v1_r;
  logic                        v2_r;
  logic                        in_fire_s;
  logic                        s2_load_s;
  logic [LANES-1:0][LOGQ:0]    raw_s;
  logic [LANES-1:0][LOGQ-1:0]  res_s;
  logic                        unused_pad_s;

  // Modulus: fixed constant, or built from the run-time high part.
  generate
    if (Q_VALUE != '0) begin : g_const_q
      logic unused_qh_s;
      assign unused_qh_s = ^qH;
      assign q_s         = Q_VALUE;
    end else begin : g_port_q
      assign q_s = {qH, {(WORD_SIZE-1){1'b0}}, 1'b1};
    end
  endgenerate

  // Stage 2 frees up when empty or draining; stage 1 likewise into stage 2.
  assign s2_load_s = v1_r && (!v2_r || out_ready);
  assign in_ready  = !v1_r || (!v2_r || out_ready);
  assign in_fire_s = in_valid && in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    modaddsub_lane #(
      .LOGQ(LOGQ)
    ) u_lane (
      .a       (in_a[i*LOGQ +: LOGQ]),
      .b       (in_b[i*LOGQ +: LOGQ]),
      .op      (in_op[i]),
      .held_raw(s1_r.val[i][LOGQ:0]),
      .held_op (s1_r.op[i]),
      .q       (q_s),
      .raw     (raw_s[i]),
      .res     (res_s[i])
    );
  end

  // Stage-1 payload: tag, per-lane op and raw sum/difference.
  always_comb begin
    s1_next_s              = '0;
    s1_next_s.tag[TAG_W-1:0] = in_tag;
    for (int i = 0; i < LANES; i++) begin
      s1_next_s.op[i]            = in_op[i];
      s1_next_s.val[i][LOGQ:0]   = raw_s[i];
    end
  end

  // Stage-2 payload: tag follows its data, lanes carry corrected results.
  always_comb begin
    s2_next_s              = '0;
    s2_next_s.tag[TAG_W-1:0] = s1_r.tag[TAG_W-1:0];
    for (int i = 0; i < LANES; i++) begin
      s2_next_s.op[i]            = s1_r.op[i];
      s2_next_s.val[i][LOGQ-1:0] = res_s[i];
    end
  end

  // Stage-1 register: load on accept, empty when handed to stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r <= 1'b0;
      s1_r <= '0;
    end else if (in_fire_s) begin
      v1_r <= 1'b1;
      s1_r <= s1_next_s;
    end else if (s2_load_s) begin
      v1_r <= 1'b0;
    end
  end

  // Stage-2 register: holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r <= 1'b0;
      s2_r <= '0;
    end else if (s2_load_s) begin
      v2_r <= 1'b1;
      s2_r <= s2_next_s;
    end else if (out_ready) begin
      v2_r <= 1'b0;
    end
  end

  // Unpack the stage-2 lanes onto the output bus.
  always_comb begin
    out_c = '0;
    for (int i = 0; i < LANES; i++) begin
      out_c[i*LOGQ +: LOGQ] = s2_r.val[i][LOGQ-1:0];
    end
  end

  assign out_valid = v2_r;
  assign out_tag   = s2_r.tag[TAG_W-1:0];

  // Payload padding beyond this configuration is constant zero.
  assign unused_pad_s = ^{s1_r, s2_r};

`ifdef MODADDSUB_RANGE_CHECK_EN
  logic oor_s;
  logic range_err_r;

  // Any lane operand at or above q on the input bus.
  always_comb begin
    oor_s = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      oor_s = oor_s | (in_a[i*LOGQ +: LOGQ] >= q_s) | (in_b[i*LOGQ +: LOGQ] >= q_s);
    end
  end

  // Sticky flag, set only by an accepted out-of-range operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      range_err_r <= 1'b0;
    end else if (in_fire_s && oor_s) begin
      range_err_r <= 1'b1;
    end
  end

  assign range_err = range_err_r;
`endif

endmodule

// File: tb/tb_modaddsub_lanes.sv
// Self-checking bench for modaddsub_lanes (LOGQ=16, WORD_SIZE=8, q=12289).
module tb_modaddsub_lanes;

  localparam int LOGQ  = 16;
  localparam int LANES = 4;
  localparam int TAG_W = 8;
  localparam int Q     = 12289;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [7:0]             qH;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES-1:0]       in_op;
  logic [LANES*LOGQ-1:0]  in_a;
  logic [LANES*LOGQ-1:0]  in_b;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*LOGQ-1:0]  out_c;
  logic [TAG_W-1:0]       out_tag;
`ifdef MODADDSUB_RANGE_CHECK_EN
  logic                   range_err;
`endif

  modaddsub_lanes #(
    .LOGQ(16), .Q_VALUE(16'd0), .WORD_SIZE(8), .LANES(4), .TAG_W(8)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef MODADDSUB_RANGE_CHECK_EN
    .range_err(range_err),
`endif
    .qH(qH), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_c(out_c), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*LOGQ-1:0] c;
    logic [TAG_W-1:0]      tag;
    int                    tick;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   tick_no     = 0;

  logic                  obs_valid, obs_ready, acc, emit;
  logic [LANES*LOGQ-1:0] obs_c;
  logic [TAG_W-1:0]      obs_tag;
  int                    obs_tick;

  // Reference: plain modular arithmetic per lane.
  function automatic logic [LANES*LOGQ-1:0] model(input logic [LANES-1:0] op,
                                                  input logic [LANES*LOGQ-1:0] a,
                                                  input logic [LANES*LOGQ-1:0] b);
    logic [LANES*LOGQ-1:0] res;
    int x, y, r;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      x = int'(a[i*LOGQ +: LOGQ]);
      y = int'(b[i*LOGQ +: LOGQ]);
      r = op[i] ? (x - y + Q) % Q : (x + y) % Q;
      res[i*LOGQ +: LOGQ] = 16'(r);
    end
    return res;
  endfunction

  function automatic logic [15:0] rnd_operand();
    int k;
    k = int'($urandom_range(0, 3));
    if (k == 0) return 16'd0;
    if (k == 1) return 16'(Q - 1);
    return 16'($urandom_range(0, Q - 1));
  endfunction

  function automatic logic [LANES*LOGQ-1:0] rnd_vec();
    logic [LANES*LOGQ-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*LOGQ +: LOGQ] = rnd_operand();
    return v;
  endfunction

  // One clock: drive at the falling edge, sample, record handshakes, step.
  task automatic tick(input logic iv, input logic [LANES-1:0] op,
                      input logic [LANES*LOGQ-1:0] a, input logic [LANES*LOGQ-1:0] b,
                      input logic [TAG_W-1:0] tag, input logic ordy, input logic r);
    @(negedge clk);
    rst = r; in_valid = iv; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = ordy;
    #1;
    obs_valid = out_valid; obs_ready = in_ready; obs_c = out_c; obs_tag = out_tag;
    obs_tick  = tick_no;
    acc  = iv && in_ready && !r;
    emit = out_valid && ordy;
    if (acc) exp_q.push_back('{model(op, a, b), tag, tick_no});
    @(posedge clk);
    #1;
    tick_no++;
  endtask

  task automatic idle(input logic ordy);
    tick(1'b0, '0, '0, '0, '0, ordy, 1'b0);
  endtask

  task automatic test_reset;
    tick(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
    tick(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
    idle(1'b0);
    vectors++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_c !== '0 || obs_tag !== '0) begin
      miscompares++;
      $display("FAIL reset_state: valid %b ready %b c %h tag %h, want 0 1 0 0",
               obs_valid, obs_ready, obs_c, obs_tag);
    end
    exp_q.delete();
  endtask

  task automatic test_add_directed;
    logic [LANES*LOGQ-1:0] a, b, want;
    a    = {16'd100, 16'd5, 16'd6000, 16'd12288};
    b    = {16'd200, 16'd6, 16'd7000, 16'd1};
    want = {16'd300, 16'd11, 16'd711, 16'd0};
    tick(1'b1, 4'b0000, a, b, 8'hA1, 1'b1, 1'b0);
    idle(1'b1);
    vectors++;
    if (obs_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_early: out_valid %b one cycle after accept, want 0", obs_valid);
    end
    idle(1'b1);
    vectors++;
    if (obs_valid !== 1'b1 || obs_c !== want || obs_tag !== 8'hA1) begin
      miscompares++;
      $display("FAIL add_directed: valid %b c %h tag %h, want 1 %h a1", obs_valid, obs_c, obs_tag, want);
    end
    exp_q.delete();
  endtask

  task automatic test_sub_directed;
    logic [LANES*LOGQ-1:0] a, b, want;
    a    = {16'd5, 16'd5, 16'd7000, 16'd0};
    b    = {16'd9, 16'd5, 16'd6000, 16'd1};
    want = {16'd12285, 16'd0, 16'd1000, 16'd12288};
    tick(1'b1, 4'b1111, a, b, 8'h5B, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    vectors++;
    if (obs_valid !== 1'b1 || obs_c !== want || obs_tag !== 8'h5B) begin
      miscompares++;
      $display("FAIL sub_directed: valid %b c %h tag %h, want 1 %h 5b", obs_valid, obs_c, obs_tag, want);
    end
    exp_q.delete();
  endtask

  task automatic test_mixed_ops;
    exp_t e;
    for (int n = 0; n < 10; n++) begin
      if (n < 6) tick(1'b1, 4'b1010, rnd_vec(), rnd_vec(), 8'(8'h40 + n), 1'b1, 1'b0);
      else idle(1'b1);
      if (emit) begin
        vectors++;
        e = exp_q.pop_front();
        if (obs_c !== e.c || obs_tag !== e.tag) begin
          miscompares++;
          $display("FAIL mixed_ops: c %h tag %h, want %h %h", obs_c, obs_tag, e.c, e.tag);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mixed_drain: %0d results missing, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   got;
    got = 0;
    for (int n = 0; n < 11; n++) begin
      if (n < 8) tick(1'b1, 4'($urandom), rnd_vec(), rnd_vec(), 8'(8'h80 + n), 1'b1, 1'b0);
      else idle(1'b1);
      vectors++;
      if (obs_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready: in_ready %b at step %0d, want 1", obs_ready, n);
      end
      if (emit) begin
        got++;
        vectors++;
        e = exp_q.pop_front();
        if (obs_c !== e.c || obs_tag !== e.tag || obs_tick != e.tick + 2) begin
          miscompares++;
          $display("FAIL b2b_result: c %h tag %h latency %0d, want %h %h latency 2",
                   obs_c, obs_tag, obs_tick - e.tick, e.c, e.tag);
        end
      end
    end
    vectors++;
    if (got != 8) begin
      miscompares++;
      $display("FAIL b2b_count: %0d results, want 8", got);
    end
    exp_q.delete();
  endtask

  task automatic test_stall;
    exp_t e, first;
    int   got;
    got = 0;
    tick(1'b1, 4'b0101, rnd_vec(), rnd_vec(), 8'hC0, 1'b0, 1'b0);
    first = exp_q[0];
    tick(1'b1, 4'b0011, rnd_vec(), rnd_vec(), 8'hC1, 1'b0, 1'b0);
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL stall_second_accept: in_ready %b with stage 2 empty, want 1", obs_ready);
    end
    for (int n = 0; n < 4; n++) begin
      tick(1'b1, 4'b1111, rnd_vec(), rnd_vec(), 8'hCF, 1'b0, 1'b0);
      vectors++;
      if (obs_ready !== 1'b0 || obs_valid !== 1'b1 || obs_c !== first.c || obs_tag !== first.tag) begin
        miscompares++;
        $display("FAIL stall_hold: ready %b valid %b c %h tag %h, want 0 1 %h %h",
                 obs_ready, obs_valid, obs_c, obs_tag, first.c, first.tag);
      end
    end
    tick(1'b1, 4'b1001, rnd_vec(), rnd_vec(), 8'hC2, 1'b1, 1'b0);
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL stall_release_accept: in_ready %b when out_ready rises, want 1", obs_ready);
    end
    if (emit) begin
      got++;
      e = exp_q.pop_front();
    end
    for (int n = 0; n < 5; n++) begin
      idle(1'b1);
      if (emit) begin
        got++;
        vectors++;
        e = exp_q.pop_front();
        if (obs_c !== e.c || obs_tag !== e.tag) begin
          miscompares++;
          $display("FAIL stall_order: c %h tag %h, want %h %h", obs_c, obs_tag, e.c, e.tag);
        end
      end
    end
    vectors++;
    if (got != 3 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stall_count: %0d results, %0d left, want 3 and 0", got, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    tick(1'b1, 4'b0000, rnd_vec(), rnd_vec(), 8'hE0, 1'b0, 1'b0);
    tick(1'b1, 4'b1111, rnd_vec(), rnd_vec(), 8'hE1, 1'b0, 1'b0);
    tick(1'b1, 4'b0110, rnd_vec(), rnd_vec(), 8'hE2, 1'b0, 1'b1);
    exp_q.delete();
    idle(1'b1);
    vectors++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_c !== '0 || obs_tag !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: valid %b ready %b c %h tag %h, want 0 1 0 0",
               obs_valid, obs_ready, obs_c, obs_tag);
    end
    for (int n = 0; n < 4; n++) begin
      idle(1'b1);
      vectors++;
      if (obs_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_stale: out_valid %b tag %h after reset, want 0", obs_valid, obs_tag);
      end
    end
  endtask

  task automatic test_random;
    exp_t e;
    logic iv, ordy;
    for (int n = 0; n < 400; n++) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      tick(iv, 4'($urandom), rnd_vec(), rnd_vec(), 8'($urandom), ordy, 1'b0);
      if (emit) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL random_spurious: output tag %h with nothing outstanding", obs_tag);
        end else begin
          e = exp_q.pop_front();
          if (obs_c !== e.c || obs_tag !== e.tag) begin
            miscompares++;
            $display("FAIL random_result: c %h tag %h, want %h %h", obs_c, obs_tag, e.c, e.tag);
          end
        end
      end
    end
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
      idle(1'b1);
      if (emit) begin
        vectors++;
        e = exp_q.pop_front();
        if (obs_c !== e.c || obs_tag !== e.tag) begin
          miscompares++;
          $display("FAIL random_drain: c %h tag %h, want %h %h", obs_c, obs_tag, e.c, e.tag);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL random_timeout: %0d results never emitted, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

`ifdef MODADDSUB_RANGE_CHECK_EN
  task automatic test_range_err;
    vectors++;
    if (range_err !== 1'b0) begin
      miscompares++;
      $display("FAIL range_clean: range_err %b with in-range operands, want 0", range_err);
    end
    tick(1'b1, 4'b0000, {48'd0, 16'd12289}, '0, 8'hF0, 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      idle(1'b1);
      vectors++;
      if (range_err !== 1'b1) begin
        miscompares++;
        $display("FAIL range_sticky: range_err %b, want 1", range_err);
      end
    end
    tick(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
    vectors++;
    if (range_err !== 1'b0) begin
      miscompares++;
      $display("FAIL range_reset: range_err %b after rst, want 0", range_err);
    end
    exp_q.delete();
  endtask
`endif

  initial begin
    rst = 1'b1; qH = 8'h30; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    in_tag = '0; out_ready = 1'b0;
    test_reset();
    test_add_directed();
    test_sub_directed();
    test_mixed_ops();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef MODADDSUB_RANGE_CHECK_EN
    test_range_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/modaddsub_lanes.md
MODADDSUB_LANES -- requirements
Module: modaddsub_lanes

Interface
REQ-001 SHALL have parameter LOGQ, default 32, the modulus and operand width in bits.
REQ-002 SHALL have parameter Q_VALUE, default 0, the constant modulus; 0 means the modulus is taken from port qH at run time.
REQ-003 SHALL have parameter WORD_SIZE, default 16; q = qH*2^WORD_SIZE + 1, so the low WORD_SIZE bits of q are 0...01.
REQ-004 SHALL have parameter LANES, default 4, the number of independent lanes processed per transaction.
REQ-005 SHALL have parameter TAG_W, default 8, the width of a sideband tag carried through unchanged.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-008 SHALL have port qH, input, LOGQ-WORD_SIZE bits, the modulus high part; ignored when Q_VALUE != 0.
REQ-009 SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit, forming the input handshake.
REQ-010 SHALL have port in_op, input, LANES bits; per lane, 0 = add and 1 = subtract (a-b).
REQ-011 SHALL have ports in_a and in_b, input, LANES*LOGQ bits each, lane i at bits [i*LOGQ +: LOGQ], each operand < q.
REQ-012 SHALL have port in_tag, input, TAG_W bits.
REQ-013 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit, forming the output handshake.
REQ-014 SHALL have port out_c, output, LANES*LOGQ bits, with the same lane packing as in_a.
REQ-015 SHALL have port out_tag, output, TAG_W bits.

Function
REQ-016 SHALL accept a transfer when in_valid && in_ready, and emit a transfer when out_valid && out_ready.
REQ-017 SHALL be a 2-stage pipeline: stage 1 registers the raw sum or difference (LOGQ+1 bits, signed for subtract); stage 2 registers the corrected result.
REQ-018 SHALL compute, for add, s = a + b, and output s - q if s - q >= 0, else s.
REQ-019 SHALL compute, for subtract, d = a - b, and output d + q if d < 0, else d.
REQ-020 SHALL produce results in [0, q) whenever both operands are < q.
REQ-021 SHALL present the result at out_valid on the 2nd rising edge after acceptance when there is no stall; throughput SHALL be 1 transaction per cycle.
REQ-022 SHALL advance each stage iff the downstream stage is empty or advancing in the same cycle; in_ready = !v1 || (!v2 || out_ready).
REQ-023 SHALL hold out_c, out_tag and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL, when full and out_ready rises, accept a new input in that same cycle with no bubble.
REQ-025 SHALL preserve order; the tag SHALL travel with its data.
REQ-026 SHALL compute each lane independently and may mix add and subtract within one transaction.
REQ-027 SHALL sample qH in stage 2 every cycle; qH SHALL be held constant while any stage is valid (a caller obligation).

Reset
REQ-028 SHALL, when rst is high at a clock edge, clear both stage valids, so out_valid = 0 and in_ready = 1 in the next cycle.
REQ-029 SHALL reset out_c and out_tag to 0.
REQ-030 SHALL discard in-flight data on a reset mid-operation and ignore an input presented in the reset cycle.

Configuration
REQ-031 SHALL, with MODADDSUB_RANGE_CHECK_EN defined, add a sticky output range_err (1 bit, reset 0) that sets when an accepted operand in any lane is >= q.
REQ-032 SHALL, without MODADDSUB_RANGE_CHECK_EN, omit range_err and its comparators entirely.

Structure
REQ-033 SHALL take the op encoding constants (OP_ADD = 0, OP_SUB = 1) and the stage payload struct (tag, per-lane values) from shared package ntt_arith_pkg.
REQ-034 SHALL implement per-lane arithmetic in sub-module modaddsub_lane (combinational add/sub and correction), instantiated LANES times.

Verification
REQ-035 SHALL pass this check (LOGQ=16, WORD_SIZE=8, qH=0x30, q=12289, lane 0): add 12288+1 -> 0; add 6000+7000 -> 711; add 5+6 -> 11.
REQ-036 SHALL pass this check: sub 0-1 -> 12288; sub 7000-6000 -> 1000; sub 5-5 -> 0; with mixed in_op=4'b1010 across lanes, each lane matches its own op.
REQ-037 SHALL pass this check: streaming 8 back-to-back transactions with out_ready=1 gives out_valid exactly 2 cycles after each accept, in order with matching tags.
REQ-038 SHALL pass this check: with out_ready=0 for 4 cycles after 2 accepts, in_ready=0 and outputs hold stable; releasing out_ready gives both results in order with no loss.
REQ-039 SHALL pass this check: asserting rst while 2 transactions are in flight gives out_valid=0 the next cycle and no stale output afterwards.
REQ-040 SHALL pass this check: with MODADDSUB_RANGE_CHECK_EN, presenting a=12289 sets range_err, which stays 1 until rst.
